uart_rx: RTL

Serial receiver for the UART peripheral. It is the downstream counterpart of the transmit path: it consumes the `rx` line and delivers parallel words to the register file (RXD / CTRL RX_VALID, RX_READY). It uses 16x oversampling from the system clock with a majority-vote bit sampler. Each received word is held in a one-entry buffer with a valid/ready handshake and per-word error flags.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive path.
package uart_pkg;
    localparam int OVS        = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    localparam int CHK_NONE = 0;
    localparam int CHK_ODD  = 1;
    localparam int CHK_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick: one-clock pulse every CLOCK/(16*BAUD) clocks, phase reset by clear.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLOCK = 25000000,
    parameter int BAUD  = 115200
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int DIV = CLOCK / (OVS * BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_bad_div
        $error("uart_baud_tick: CLOCK/(16*BAUD) must be at least 1");
    end

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clock) begin
        if (reset || clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop sync, 16x oversampled majority-vote sampler, one-word holding buffer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK = 25000000,
    parameter int BAUD  = 115200,
    parameter int DBIT  = 8,
    parameter int SBIT  = 1,
    parameter int CHECK = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] data,
    output logic            valid,
    input  logic            ready,
    output logic            frame_err,
    output logic            parity_err,
    output logic            overrun,
    output logic            busy
);
    localparam int BW = $clog2(DBIT + 1);
    localparam int PW = $clog2(OVS);

    if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
        $error("uart_rx: DBIT must be 5..9");
    end
    if (SBIT < 1 || SBIT > 2) begin : g_bad_sbit
        $error("uart_rx: SBIT must be 1 or 2");
    end
    if (CHECK < CHK_NONE || CHECK > CHK_EVEN) begin : g_bad_check
        $error("uart_rx: CHECK must be 0, 1 or 2");
    end

    rx_state_t state, state_nx;

    logic            rx_s1, rx_s2, rx_d;
    logic            fall;
    logic            tick, tick_clr;
    logic [PW-1:0]   ph;
    logic            s_lo, s_mid, s_hi, bit_end;
    logic            smp_lo, smp_mid, maj;
    logic [BW-1:0]   bit_cnt;
    logic            stop_idx, last_stop;
    logic            ferr_acc, perr_r;
    logic [DBIT-1:0] shreg;
    logic            done, load;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fall = rx_d & ~rx_s2;

    // Tick divider and bit phase sit at zero in IDLE so bit timing starts at the detected edge.
    assign tick_clr = (state == IDLE);

    uart_baud_tick #(
        .CLOCK(CLOCK),
        .BAUD (BAUD)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .clear(tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clock) begin
        if (reset || tick_clr)
            ph <= '0;
        else if (tick)
            ph <= ph + 1'b1;
    end

    // ph holds ticks already elapsed in the bit, so tick N of the bit fires while ph == N-1.
    assign s_lo    = tick && (ph == PW'(SAMPLE_LO - 1));
    assign s_mid   = tick && (ph == PW'(SAMPLE_MID - 1));
    assign s_hi    = tick && (ph == PW'(SAMPLE_HI - 1));
    assign bit_end = tick && (ph == PW'(OVS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            smp_lo  <= 1'b1;
            smp_mid <= 1'b1;
        end else begin
            if (s_lo)  smp_lo  <= rx_s2;
            if (s_mid) smp_mid <= rx_s2;
        end
    end

    assign maj       = (smp_lo & smp_mid) | (smp_lo & rx_s2) | (smp_mid & rx_s2);
    assign last_stop = (stop_idx == 1'(SBIT - 1));

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        unique case (state)
            IDLE:   if (fall) state_nx = START;
            START: begin
                if (s_hi && maj)
                    state_nx = IDLE;
                else if (bit_end)
                    state_nx = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == BW'(DBIT))
                    state_nx = (CHECK != CHK_NONE) ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_nx = STOP;
            STOP: begin
                // Finish at the last stop sample so a following start edge is not missed.
                if (s_hi && last_stop) begin
                    done     = 1'b1;
                    state_nx = (ferr_acc || !maj) ? BREAK : IDLE;
                end
            end
            BREAK:  if (rx_s2) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            ferr_acc <= 1'b0;
            perr_r   <= 1'b0;
            shreg    <= '0;
        end else begin
            if (state == IDLE) begin
                bit_cnt  <= '0;
                stop_idx <= 1'b0;
                ferr_acc <= 1'b0;
                perr_r   <= 1'b0;
            end
            if (s_hi) begin
                case (state)
                    DATA: begin
                        shreg   <= {maj, shreg[DBIT-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: perr_r <= (CHECK == CHK_ODD) ? ~(^shreg ^ maj) : (^shreg ^ maj);
                    STOP: begin
                        if (!maj) ferr_acc <= 1'b1;
                        stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign load = done && (!valid || ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= done && valid && !ready;
            if (load) begin
                data       <= shreg;
                valid      <= 1'b1;
                frame_err  <= ferr_acc | ~maj;
                parity_err <= perr_r;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);
endmodule
